periodic_timer_ctrl: RTL and testbench

//   Programmable timer controller that sequences two binary_upcounter instances.
//   One is a prescaler; the other is the period counter.
//   - Loads the counters and gates their enables.
//   - Reloads them at terminal count.
//   - Produces a tick pulse and a sticky irq, in one-shot or periodic mode.
//   - Sits between a control/status register block and interrupt logic.

---
 rtl/periodic_timer_ctrl_pkg.sv | 12 +
 rtl/periodic_timer_ctrl_if.sv | 26 ++
 rtl/periodic_timer_ctrl_binary_upcounter.sv | 23 ++
 rtl/periodic_timer_ctrl.sv | 95 +++++++++
 tb/tb_periodic_timer_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/periodic_timer_ctrl_pkg.sv
// Shared definitions for the periodic timer controller: FSM state encodings.
package periodic_timer_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN
    } state_t;
endpackage

// File: rtl/periodic_timer_ctrl_if.sv
// Control/status bundle between the register block (master) and the timer (slave).
interface periodic_timer_ctrl_if #(
    parameter int BITS          = 16,
    parameter int PRESCALE_BITS = 8
);
    logic [BITS-1:0]          cfg_period;
    logic [PRESCALE_BITS-1:0] cfg_prescale;
    logic                     cfg_oneshot;
    logic                     start;
    logic                     stop;
    logic                     irq_ack;
    logic                     busy;
    logic                     tick;
    logic                     irq;
    logic [BITS-1:0]          remaining;

    modport master (
        output cfg_period, cfg_prescale, cfg_oneshot, start, stop, irq_ack,
        input  busy, tick, irq, remaining
    );

    modport slave (
        input  cfg_period, cfg_prescale, cfg_oneshot, start, stop, irq_ack,
        output busy, tick, irq, remaining
    );
endinterface

// File: rtl/periodic_timer_ctrl_binary_upcounter.sv
// Loadable binary up-counter; ovf flags the all-ones value (next increment wraps).
module binary_upcounter #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            ena,
    input  logic [BITS-1:0] value,
    output logic [BITS-1:0] count,
    output logic            ovf
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= value;
        else if (ena)
            count <= count + 1'b1;
    end

    assign ovf = &count;
endmodule

// File: rtl/periodic_timer_ctrl.sv
// Timer controller: sequences a prescaler and a period counter, emits tick and sticky irq.
module periodic_timer_ctrl
    import periodic_timer_ctrl_pkg::*;
#(
    parameter int BITS          = 16,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    periodic_timer_ctrl_if.slave  bus
);
    state_t                   state, state_nxt;
    logic [BITS-1:0]          period_sh;
    logic [PRESCALE_BITS-1:0] prescale_sh;
    logic                     oneshot_sh;
    logic [PRESCALE_BITS-1:0] presc_cnt;
    logic [BITS-1:0]          period_cnt;
    logic                     presc_ovf, period_ovf;
    logic                     presc_load, presc_ena, period_load, period_ena;
    logic                     start_ok, run_go, terminal;
    logic                     tick_q, irq_q;

    // stop beats start beats terminal: counting only advances on an undisturbed RUN cycle
    assign start_ok = bus.start & ~bus.stop;
    assign run_go   = (state == RUN) & ~bus.start & ~bus.stop;
    assign terminal = run_go & presc_ovf & period_ovf;

    assign presc_load  = (state == LOAD) | (run_go & presc_ovf);
    assign presc_ena   = run_go;
    assign period_load = (state == LOAD) | (terminal & ~oneshot_sh);
    // one-shot expiry freezes the period counter so remaining holds 0 in IDLE
    assign period_ena  = run_go & presc_ovf & ~(period_ovf & oneshot_sh);

    binary_upcounter #(.BITS(PRESCALE_BITS)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .load  (presc_load),
        .ena   (presc_ena),
        .value (~prescale_sh),
        .count (presc_cnt),
        .ovf   (presc_ovf)
    );

    binary_upcounter #(.BITS(BITS)) u_period (
        .clk   (clk),
        .rst   (rst),
        .load  (period_load),
        .ena   (period_ena),
        .value (~period_sh),
        .count (period_cnt),
        .ovf   (period_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = LOAD;
            LOAD: begin
                if (bus.stop)        state_nxt = IDLE;
                else if (!bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (bus.stop)                    state_nxt = IDLE;
                else if (bus.start)              state_nxt = LOAD;
                else if (terminal && oneshot_sh) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            period_sh   <= '0;
            prescale_sh <= '0;
            oneshot_sh  <= 1'b0;
            tick_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state  <= state_nxt;
            tick_q <= terminal;
            irq_q  <= tick_q | (irq_q & ~bus.irq_ack);
            if (start_ok) begin
                period_sh   <= bus.cfg_period;
                prescale_sh <= bus.cfg_prescale;
                oneshot_sh  <= bus.cfg_oneshot;
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.tick      = tick_q;
    assign bus.irq       = irq_q;
    assign bus.remaining = ~period_cnt;
endmodule

// File: tb/tb_periodic_timer_ctrl.sv
// Directed checks of periodic_timer_ctrl timing, priority and irq behaviour.
module tb_periodic_timer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    periodic_timer_ctrl_if #(.BITS(16), .PRESCALE_BITS(8)) bus ();

    periodic_timer_ctrl #(.BITS(16), .PRESCALE_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, land 1ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // returns 1ns after the edge that samples start (that edge is t0)
    task automatic cfg_start(input logic [15:0] p, input logic [7:0] s, input logic o);
        bus.cfg_period   = p;
        bus.cfg_prescale = s;
        bus.cfg_oneshot  = o;
        bus.start        = 1'b1;
        step(1);
        bus.start        = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        bus.cfg_period   = '0;
        bus.cfg_prescale = '0;
        bus.cfg_oneshot  = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.irq_ack      = 1'b0;

        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_irq",  32'(bus.irq), 0);
        chk("rst_rem",  32'(bus.remaining), 32'hffff);
        #10 rst = 1'b1;
        step(1);

        // periodic P=3 S=0: ticks at t0+5, +9, +13
        cfg_start(16'd3, 8'd0, 1'b0);
        chk("t1_busy_load", 32'(bus.busy), 1);
        step(1); chk("t1_rem_load", 32'(bus.remaining), 3);
        step(3); chk("t1_tick_t4",  32'(bus.tick), 0);
        step(1); chk("t1_tick_t5",  32'(bus.tick), 1);
        step(1); chk("t1_tick_t6",  32'(bus.tick), 0);
        chk("t1_busy_t6", 32'(bus.busy), 1);
        step(3); chk("t1_tick_t9",  32'(bus.tick), 1);
        step(4); chk("t1_tick_t13", 32'(bus.tick), 1);
        chk("t1_busy_t13", 32'(bus.busy), 1);
        pulse_stop();
        step(2);
        pulse_ack();
        chk("t1_irq_clr", 32'(bus.irq), 0);
        chk("t1_busy_stop", 32'(bus.busy), 0);

        // one-shot P=2 S=3: single tick at t0+13
        cfg_start(16'd2, 8'd3, 1'b1);
        step(12); chk("t2_tick_t12", 32'(bus.tick), 0);
        chk("t2_busy_t12", 32'(bus.busy), 1);
        step(1);  chk("t2_tick_t13", 32'(bus.tick), 1);
        chk("t2_busy_t13", 32'(bus.busy), 0);
        step(1);  chk("t2_tick_t14", 32'(bus.tick), 0);
        chk("t2_irq_t14", 32'(bus.irq), 1);
        chk("t2_rem_idle", 32'(bus.remaining), 0);
        step(5);  chk("t2_irq_sticky", 32'(bus.irq), 1);
        chk("t2_tick_quiet", 32'(bus.tick), 0);
        pulse_ack();
        chk("t2_irq_ack", 32'(bus.irq), 0);

        // P=0 S=0 periodic: tick continuously from t0+2
        cfg_start(16'd0, 8'd0, 1'b0);
        step(1); chk("t3_rem_t1",  32'(bus.remaining), 0);
        chk("t3_tick_t1", 32'(bus.tick), 0);
        step(1); chk("t3_tick_t2", 32'(bus.tick), 1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t3_tick_run", 32'(bus.tick), 1);
            chk("t3_rem_run",  32'(bus.remaining), 0);
        end
        pulse_stop();
        step(2);
        pulse_ack();
        chk("t3_irq_clr", 32'(bus.irq), 0);

        // stop in the terminal cycle suppresses tick and irq
        cfg_start(16'd3, 8'd0, 1'b0);
        step(4); chk("t4_tick_t4", 32'(bus.tick), 0);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        chk("t4_tick_t5", 32'(bus.tick), 0);
        chk("t4_busy_t5", 32'(bus.busy), 0);
        chk("t4_irq_t5",  32'(bus.irq), 0);
        step(1);
        chk("t4_tick_t6", 32'(bus.tick), 0);
        chk("t4_irq_t6",  32'(bus.irq), 0);

        // mid-run cfg change ignored until restart
        cfg_start(16'd3, 8'd0, 1'b0);
        step(2); bus.cfg_period = 16'd1;
        step(3); chk("t5_tick_t5", 32'(bus.tick), 1);
        step(2); chk("t5_tick_t7", 32'(bus.tick), 0);
        step(2); chk("t5_tick_t9", 32'(bus.tick), 1);
        cfg_start(16'd1, 8'd0, 1'b0);
        step(2); chk("t5_new_t2", 32'(bus.tick), 0);
        step(1); chk("t5_new_t3", 32'(bus.tick), 1);
        step(1); chk("t5_new_t4", 32'(bus.tick), 0);
        step(1); chk("t5_new_t5", 32'(bus.tick), 1);
        pulse_stop();
        step(2);
        pulse_ack();
        chk("t5_irq_clr", 32'(bus.irq), 0);

        // irq_ack during tick: set wins; then async reset mid-run
        cfg_start(16'd3, 8'd0, 1'b0);
        step(5); chk("t6_tick_t5", 32'(bus.tick), 1);
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
        chk("t6_irq_setwin", 32'(bus.irq), 1);
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
        chk("t6_irq_acked", 32'(bus.irq), 0);
        step(6); chk("t6_tick_t13", 32'(bus.tick), 1);
        chk("t6_irq_t13", 32'(bus.irq), 1);
        #3 rst = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_tick", 32'(bus.tick), 0);
        chk("t6_rst_irq",  32'(bus.irq), 0);
        chk("t6_rst_rem",  32'(bus.remaining), 32'hffff);
        #2 rst = 1'b1;
        step(3);
        chk("t6_post_tick", 32'(bus.tick), 0);
        chk("t6_post_busy", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
